// File: rtl/mem_pkg.sv
// Shared types for the MEM stage: access-size codes, FSM states and size decode.
package mem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_D  = 3'b011,
    F3_BU = 3'b100,
    F3_HU = 3'b101,
    F3_WU = 3'b110
  } funct3_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic       legal;
    logic       is_unsigned;
    logic [1:0] size;        // log2 of the access size in bytes
  } size_dec_t;

  function automatic size_dec_t decode_size(input logic [2:0] f3, input logic is_store,
                                            input logic rv64);
    size_dec_t d;
    d.legal       = 1'b1;
    d.is_unsigned = f3[2];
    d.size        = f3[1:0];
    case (f3)
      F3_B, F3_H, F3_W: d.legal = 1'b1;
      F3_D:             d.legal = rv64;
      F3_BU, F3_HU:     d.legal = ~is_store;
      F3_WU:            d.legal = rv64 & ~is_store;
      default:          d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane select and sign/zero extension of the returned memory word.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]           rdata,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [1:0]                size,
  input  logic                      is_unsigned,
  output logic [XLEN-1:0]           data
);

  localparam int SH_W = $clog2(XLEN);

  logic        [XLEN-1:0] lane;
  logic signed [XLEN-1:0] up;
  logic        [SH_W-1:0] shamt;

  // Left-justify the selected lane, then shift back arithmetically or logically.
  always_comb begin
    lane = rdata >> {offset, 3'b000};
    case (size)
      2'd0:    shamt = SH_W'(XLEN - 8);
      2'd1:    shamt = SH_W'(XLEN - 16);
      2'd2:    shamt = SH_W'(XLEN - 32);
      default: shamt = '0;
    endcase
    up   = lane << shamt;
    data = is_unsigned ? ($unsigned(up) >> shamt) : $unsigned(up >>> shamt);
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores over a ready handshake, stalls while
// waiting, formats load data and store lanes, and registers results for WB.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                valid_i,
  input  logic [XLEN-1:0]     alu_out_i,
  input  logic [XLEN-1:0]     rs2_data_i,
  input  logic [XLEN-1:0]     imm_i,
  input  logic [XLEN-1:0]     pc_plus4_i,
  input  logic [REG_AW-1:0]   rd_i,
  input  logic                reg_write_i,
  input  logic [1:0]          write_src_i,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic [2:0]          funct3_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [XLEN-1:0]     mem_addr_o,
  output logic [XLEN-1:0]     mem_wdata_o,
  output logic [XLEN/8-1:0]   mem_be_o,
  input  logic                mem_ready_i,
  input  logic [XLEN-1:0]     mem_rdata_i,
  output logic                valid_o,
  output logic                reg_write_o,
  output logic [1:0]          write_src_o,
  output logic [XLEN-1:0]     alu_out_o,
  output logic [XLEN-1:0]     mem_data_o,
  output logic [XLEN-1:0]     imm_o,
  output logic [XLEN-1:0]     pc_plus4_o,
  output logic [REG_AW-1:0]   rd_o,
  output logic                misalign_o,
  output logic                bus_err_o
);

  localparam int NB    = XLEN / 8;
  localparam int OFFW  = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic RV64  = (XLEN == 64);
  localparam logic TO_EN = (TIMEOUT > 0);

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             req, stall, capture, wb_load, wb_misalign, wb_buserr;
  logic             in_wait, kill, timeout_hit;

  size_dec_t        dec;
  logic             is_mem, live, misalign_in;
  logic [OFFW-1:0]  off_in, size_mask;
  logic [XLEN-1:0]  addr_al_in, wdata_in;
  logic [NB-1:0]    be_in;

  logic [XLEN-1:0]   c_addr, c_wdata, c_alu, c_imm, c_pc4;
  logic [NB-1:0]     c_be;
  logic [OFFW-1:0]   c_off;
  logic [1:0]        c_size, c_ws;
  logic [REG_AW-1:0] c_rd;
  logic              c_uns, c_we, c_load, c_rw, c_flushed;

  logic [XLEN-1:0]  ld_data;
  logic [OFFW-1:0]  al_off;
  logic [1:0]       al_size;
  logic             al_uns;

  // Request decode straight from the EX/MEM inputs
  assign dec         = decode_size(funct3_i, mem_write_i, RV64);
  assign is_mem      = mem_read_i | mem_write_i;
  assign live        = valid_i & ~flush_i;
  assign off_in      = alu_out_i[OFFW-1:0];
  assign size_mask   = OFFW'((1 << dec.size) - 1);
  assign misalign_in = is_mem & (~dec.legal | (|(off_in & size_mask)));
  assign addr_al_in  = {alu_out_i[XLEN-1:OFFW], {OFFW{1'b0}}};

  always_comb begin
    case (dec.size)
      2'd0:    be_in = NB'(1);
      2'd1:    be_in = NB'(3);
      2'd2:    be_in = NB'(15);
      default: be_in = '1;
    endcase
    be_in = be_in << off_in;
  end

  always_comb begin
    wdata_in = rs2_data_i;
    for (int i = 0; i < NB; i++) begin
      case (dec.size)
        2'd0:    wdata_in[8*i +: 8] = rs2_data_i[7:0];
        2'd1:    wdata_in[8*i +: 8] = rs2_data_i[8*(i % 2) +: 8];
        2'd2:    wdata_in[8*i +: 8] = rs2_data_i[8*(i % 4) +: 8];
        default: wdata_in[8*i +: 8] = rs2_data_i[8*i +: 8];
      endcase
    end
  end

  // Bus side: live decode in IDLE, captured request held stable while waiting
  assign in_wait     = (state == WAIT);
  assign kill        = c_flushed | flush_i;
  assign timeout_hit = TO_EN && (cnt == CNT_LAST);

  assign stall_o     = stall;
  assign mem_req_o   = req;
  assign mem_we_o    = req & (in_wait ? c_we : mem_write_i);
  assign mem_addr_o  = in_wait ? c_addr  : addr_al_in;
  assign mem_wdata_o = in_wait ? c_wdata : wdata_in;
  assign mem_be_o    = req ? (in_wait ? c_be : be_in) : '0;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    req         = 1'b0;
    stall       = 1'b0;
    capture     = 1'b0;
    wb_load     = 1'b0;
    wb_misalign = 1'b0;
    wb_buserr   = 1'b0;
    case (state)
      IDLE: begin
        if (live) begin
          if (misalign_in) begin
            wb_load     = 1'b1;
            wb_misalign = 1'b1;
          end else if (is_mem) begin
            req = 1'b1;
            if (mem_ready_i) begin
              wb_load = 1'b1;
            end else begin
              stall   = 1'b1;
              capture = 1'b1;
              cnt_n   = '0;
              state_n = WAIT;
            end
          end else begin
            wb_load = 1'b1;
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (mem_ready_i) begin
          wb_load = ~kill;
          state_n = IDLE;
        end else if (timeout_hit) begin
          wb_load   = ~kill;
          wb_buserr = 1'b1;
          state_n   = IDLE;
        end else begin
          stall = 1'b1;
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (reset_i) begin
      req     = 1'b0;
      stall   = 1'b0;
      capture = 1'b0;
      state_n = IDLE;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      cnt       <= '0;
      c_flushed <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (capture)
        c_flushed <= 1'b0;
      else if (in_wait && flush_i)
        c_flushed <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture) begin
      c_addr  <= addr_al_in;
      c_wdata <= wdata_in;
      c_be    <= be_in;
      c_off   <= off_in;
      c_size  <= dec.size;
      c_uns   <= dec.is_unsigned;
      c_we    <= mem_write_i;
      c_load  <= mem_read_i;
      c_rw    <= reg_write_i;
      c_ws    <= write_src_i;
      c_rd    <= rd_i;
      c_alu   <= alu_out_i;
      c_imm   <= imm_i;
      c_pc4   <= pc_plus4_i;
    end
  end

  assign al_off  = in_wait ? c_off  : off_in;
  assign al_size = in_wait ? c_size : dec.size;
  assign al_uns  = in_wait ? c_uns  : dec.is_unsigned;

  mem_load_align #(.XLEN(XLEN)) u_align (
    .rdata       (mem_rdata_i),
    .offset      (al_off),
    .size        (al_size),
    .is_unsigned (al_uns),
    .data        (ld_data)
  );

  // MEM/WB boundary
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_o     <= 1'b0;
      reg_write_o <= 1'b0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
      write_src_o <= '0;
      alu_out_o   <= '0;
      mem_data_o  <= '0;
      imm_o       <= '0;
      pc_plus4_o  <= '0;
      rd_o        <= '0;
    end else if (wb_load) begin
      valid_o     <= 1'b1;
      reg_write_o <= (in_wait ? c_rw : reg_write_i) & ~wb_misalign & ~wb_buserr;
      misalign_o  <= wb_misalign;
      bus_err_o   <= wb_buserr;
      write_src_o <= in_wait ? c_ws  : write_src_i;
      alu_out_o   <= in_wait ? c_alu : alu_out_i;
      imm_o       <= in_wait ? c_imm : imm_i;
      pc_plus4_o  <= in_wait ? c_pc4 : pc_plus4_i;
      rd_o        <= in_wait ? c_rd  : rd_i;
      mem_data_o  <= ((in_wait ? c_load : mem_read_i) & ~wb_misalign & ~wb_buserr)
                     ? ld_data : '0;
    end else begin
      valid_o     <= 1'b0;
      reg_write_o <= 1'b0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised MEM pipeline stage sitting between the EX/MEM and MEM/WB boundaries of the core. It issues loads and stores to a variable-latency data-memory port with a request/ready handshake, and stalls the upstream pipeline while an access is outstanding. It formats load data (byte/half/word/double, signed/unsigned) and store byte-enables, flags misaligned and timed-out accesses, and registers all results for the WB stage.

## Interface
Parameters:
- XLEN, 32, datapath width; 32 or 64 only.
- REG_AW, 5, destination register address width.
- TIMEOUT, 64, max cycles waiting on mem_ready_i before abort; 0 disables.

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- valid_i  in  1  EX/MEM slot holds a live instruction.
- alu_out_i  in  XLEN  address or ALU result.
- rs2_data_i  in  XLEN  store data.
- imm_i, pc_plus4_i  in  XLEN  passed through to WB.
- rd_i  in  REG_AW  destination register.
- reg_write_i  in  1  writes rd.
- write_src_i  in  2  WB mux select, passed through.
- mem_read_i, mem_write_i  in  1  load / store.
- funct3_i  in  3  access size/sign.
- flush_i  in  1  kill the instruction in this stage.
- stall_o  out  XLEN-independent 1  upstream must hold.
- mem_req_o  out  1  access request.
- mem_we_o  out  1  write.
- mem_addr_o  out  XLEN  naturally aligned address (low log2(XLEN/8) bits zero).
- mem_wdata_o  out  XLEN  lane-replicated store data.
- mem_be_o  out  XLEN/8  byte enables.
- mem_ready_i  in  1  access complete this cycle; rdata valid.
- mem_rdata_i  in  XLEN  read data.
- valid_o, reg_write_o  out  1  WB slot live / writes rd.
- write_src_o  out  2; alu_out_o, mem_data_o, imm_o, pc_plus4_o  out  XLEN; rd_o  out  REG_AW.
- misalign_o, bus_err_o  out  1  exception flags for the WB slot.

## Operation
- FSM states: IDLE, WAIT.
- IDLE, valid_i with no memory op: registered pass-through next edge, stall_o=0.
- IDLE, valid_i with load/store, aligned: mem_req_o=1 same cycle, combinational from inputs. If mem_ready_i=1 the access completes this cycle (zero-wait). Otherwise capture the request into internal registers, go to WAIT, stall_o=1.
- WAIT: drive the captured request; stall_o=1 until the completion cycle; WB slot gets bubbles (valid_o=0, reg_write_o=0). On mem_ready_i: complete, stall_o=0 that cycle, go to IDLE.
- Timeout: wait counter increments each WAIT cycle. When it reaches TIMEOUT without ready: drop the request, complete with bus_err_o=1, reg_write_o=0, return to IDLE.
- Load formatting:
  - funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - 011 LD and 110 LWU only when XLEN=64; otherwise treated as misaligned/illegal.
  - Lane is selected by the low address bits; result is sign- or zero-extended to XLEN.
- Store formatting:
  - SB/SH/SW/SD set the byte enables for the addressed lanes.
  - The data value is replicated across all lanes.
- Misaligned access (address not a multiple of the size): no request issued; completes in one cycle with misalign_o=1, reg_write_o=0.
- flush_i:
  - In IDLE: the slot becomes a bubble.
  - In WAIT with a store already issued: the store completes, its result is discarded.
  - In WAIT with a load: the request is held to completion (the bus is never abandoned mid-handshake) and the result is discarded.
- reg_write_o = reg_write_i && valid && !flushed && !misalign && !bus_err.

## Timing
- Pass-through latency: 1 cycle. Zero-wait memory: 1 cycle. N wait cycles: N+1 cycles.
- mem_req_o must remain asserted and all mem_* outputs must remain stable from assertion until the mem_ready_i cycle.
- reset_i forces IDLE, clears the wait counter, and drops mem_req_o combinationally on the reset cycle. Reset arriving mid-WAIT abandons the access.
- Reset values: valid_o=0, reg_write_o=0, misalign_o=0, bus_err_o=0, stall_o=0, mem_req_o=0, all data outputs 0.
- A mem_ready_i arriving on the same cycle as the TIMEOUT count is treated as success; ready takes priority.

## Structure
- Package mem_pkg: funct3 load/store enum, state enum (IDLE, WAIT), size-decode function.
- Sub-module mem_load_align: combinational lane select and extension, parametrised by XLEN.
- Store formatting and the FSM live in the top module.

## Test plan
- ALU op, reg_write_i=1, rd=5, alu_out=0x1234 -> next cycle valid_o=1, rd_o=5, alu_out_o=0x1234, stall_o never high.
- LB at 0x103, mem_ready_i asserted after 3 cycles, rdata=0x80FF_FF00 -> stall_o high 3 cycles, then mem_data_o=0xFFFF_FF80; LBU on the same access -> 0x0000_0080.
- SH at 0x102, data 0xABCD -> mem_be_o=4'b1100, mem_wdata_o=0xABCD_ABCD, mem_addr_o=0x100.
- LW at 0x102 -> no mem_req_o, misalign_o=1, reg_write_o=0, 1-cycle latency.
- TIMEOUT=4, mem_ready_i never asserted -> bus_err_o=1 after 4 WAIT cycles, stall_o released; ready coinciding with the 4th cycle -> normal completion.
- reset_i asserted on the 2nd WAIT cycle -> mem_req_o=0 and all outputs at reset values on the next edge; the following load issues normally.
